mem_load_unit: RTL and testbench
================================

// Module: mem_load_unit
// PURPOSE
//  Load path between the core and the data memory; the read-side counterpart of the store aligner.
//  Accepts a byte/half/word load, issues one word-aligned memory read and waits for the data.
//  Extracts the addressed lane (right shift by addr[1:0]*8), then sign- or zero-extends it.
//  Returns the 32-bit result with a one-cycle done pulse.
// PARAMETERS
//  AW       32  address width
//  TIMEOUT  15  max WAIT cycles for mem_rvalid before erroring (4-bit counter, 1..15)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  ld_valid   in   1   load request
//  ld_ready   out  1   unit idle; request accepted when ld_valid&&ld_ready
//  ld_addr    in   AW  byte address
//  ld_type    in   3   funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  ld_done    out  1   one-cycle completion pulse
//  ld_rdata   out  32  extended result, valid when ld_done
//  ld_err     out  1   error flag, valid when ld_done
//  mem_rd_en  out  1   one-cycle read strobe
//  mem_addr   out  AW  {addr[AW-1:2],2'b00}
//  mem_rdata  in   32  memory word
//  mem_rvalid in   1   mem_rdata valid
// BEHAVIOUR
//  Reset: state=IDLE; ld_ready=1; all other outputs 0; counter 0; latched addr/type 0.
//  FSM: IDLE -> REQ -> WAIT -> DONE -> IDLE.
//   IDLE: ld_ready=1. On accept, latch addr and type, then go to REQ.
//         Illegal type (011,110,111): go directly to DONE with err=1; no memory access.
//   REQ:  mem_rd_en=1 and mem_addr driven for exactly one cycle; clear counter; go to WAIT.
//   WAIT: sample mem_rvalid only in this state.
//         If set: register the extracted data, go to DONE.
//         Else: increment counter. When counter==TIMEOUT, go to DONE with err=1 and rdata=0.
//   DONE: ld_done=1 for one cycle with ld_rdata/ld_err; ld_ready=0; return to IDLE.
//  ld_rdata/ld_err hold their value until the next DONE.
//  Latency (cycles after accept edge): mem_rd_en +1, earliest rvalid +2, ld_done +3.
//  Extract: s = mem_rdata >> {addr[1:0],3'b000}.
//   LB  = {{24{s[7]}},s[7:0]}     LBU = {24'b0,s[7:0]}
//   LH  = {{16{s[15]}},s[15:0]}   LHU = {16'b0,s[15:0]}
//   LW  = s
//  mem_rvalid outside WAIT (including late after timeout, or after reset) is ignored.
//  ld_valid while busy is not accepted; the requester holds it.
//  Reset mid-operation aborts immediately: no ld_done, mem_rd_en drops asynchronously.
// CONFIGURATION
//  MEM_LOAD_MISALIGN_TRAP_EN defined:
//   LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, goes IDLE->DONE with err=1 and rdata=0.
//   No mem_rd_en is issued.
//  Not defined:
//   Misaligned loads are issued normally; vacated upper bytes of s are zero-filled by the shift.
//   Example: LH @..11 returns {16'b0,8'b0,byte3}; sign bit s[15] is 0.
// STRUCTURE
//  Shared include mem_load_defs.vh: funct3 load codes, FSM state encodings (2-bit).
//  Sub-module load_extract (combinational): inputs mem_rdata, addr[1:0], type; output 32-bit result.
//  The store aligner reuses the same funct3 constants from this include.
// TESTING
//  1 LW @0x100, rvalid 1 cycle after rd_en, rdata=0xDEADBEEF
//    -> mem_addr=0x100; ld_done at accept+3; rdata=0xDEADBEEF; err=0.
//  2 LB @0x103 rdata=0x80123456 -> 0xFFFFFF80.
//    LBU @0x103 -> 0x00000080.
//    LH @0x102 -> 0xFFFF8012.
//    LHU @0x102 -> 0x00008012.
//  3 LW, no rvalid for TIMEOUT=15 cycles -> ld_done err=1 rdata=0.
//    rvalid arriving 2 cycles later is ignored: no second ld_done.
//  4 ld_type=3'b011 -> ld_done at accept+1, err=1, mem_rd_en never asserted.
//  5 LH @0x101: with MEM_LOAD_MISALIGN_TRAP_EN -> err=1, no mem_rd_en.
//    Without it, rdata=0x12345678 -> 0x00003456.
//  6 rst_n low during WAIT -> outputs 0 and ld_ready=1 after release.
//    Pending rvalid ignored; next LW completes normally.

Source files
------------

// File: rtl/mem_load_unit_pkg.sv
// rtl/mem_load_unit_pkg.sv - funct3 load codes, FSM states and decode helpers for mem_load_unit
package mem_load_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic type_legal(input logic [2:0] t);
    case (t)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] off);
    case (t)
      F3_LH, F3_LHU: return off[0];
      F3_LW:         return off != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_unit_if.sv
// rtl/mem_load_unit_if.sv - core load request and data memory read bus for mem_load_unit
interface mem_load_unit_if #(parameter int AW = 32);
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [2:0]    ld_type;
  logic          ld_done;
  logic [31:0]   ld_rdata;
  logic          ld_err;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          mem_rvalid;

  modport slave (
    input  ld_valid, ld_addr, ld_type, mem_rdata, mem_rvalid,
    output ld_ready, ld_done, ld_rdata, ld_err, mem_rd_en, mem_addr
  );

  modport master (
    output ld_valid, ld_addr, ld_type, mem_rdata, mem_rvalid,
    input  ld_ready, ld_done, ld_rdata, ld_err, mem_rd_en, mem_addr
  );
endinterface

// File: rtl/mem_load_unit_extract.sv
// rtl/mem_load_unit_extract.sv - load_extract: lane shift by byte offset then sign/zero extension
module load_extract
  import mem_load_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  ld_type,
  output logic [31:0] result
);

  logic [31:0] s;

  // Misaligned lanes shift zeros into the top, so a straddling half never sees a sign bit.
  assign s = rdata >> {offset, 3'b000};

  always_comb begin
    result = 32'b0;
    case (ld_type)
      F3_LB:   result = {{24{s[7]}}, s[7:0]};
      F3_LBU:  result = {24'b0, s[7:0]};
      F3_LH:   result = {{16{s[15]}}, s[15:0]};
      F3_LHU:  result = {16'b0, s[15:0]};
      F3_LW:   result = s;
      default: result = 32'b0;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// rtl/mem_load_unit.sv - load unit: one aligned memory read per load, lane extract, timeout error
// Optional misaligned-load trap under `MEM_LOAD_MISALIGN_TRAP_EN.
module mem_load_unit
  import mem_load_unit_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 15
) (
  input logic           clk,
  input logic           rst_n,
  mem_load_unit_if.slave bus
);

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [2:0]    type_q;
  logic [3:0]    cnt_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   ext;
  logic          trap;
  logic          fin;
  logic [31:0]   fin_data;
  logic          fin_err;

`ifdef MEM_LOAD_MISALIGN_TRAP_EN
  assign trap = misaligned(bus.ld_type, bus.ld_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  load_extract u_extract (
    .rdata   (bus.mem_rdata),
    .offset  (addr_q[1:0]),
    .ld_type (type_q),
    .result  (ext)
  );

  always_comb begin
    state_d  = state_q;
    fin      = 1'b0;
    fin_data = 32'b0;
    fin_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ld_valid) begin
          if (!type_legal(bus.ld_type) || trap) begin
            state_d = ST_DONE;
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d  = ST_DONE;
          fin      = 1'b1;
          fin_data = ext;
        end else if (cnt_q == CNT_LAST) begin
          // This idle cycle is the TIMEOUT-th one without data.
          state_d = ST_DONE;
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      type_q  <= 3'b0;
      cnt_q   <= 4'd0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && bus.ld_valid) begin
        addr_q <= bus.ld_addr;
        type_q <= bus.ld_type;
      end
      if (state_q == ST_REQ) begin
        cnt_q <= 4'd0;
      end else if (state_q == ST_WAIT && !bus.mem_rvalid) begin
        cnt_q <= cnt_q + 4'd1;
      end
      if (fin) begin
        rdata_q <= fin_data;
        err_q   <= fin_err;
      end
    end
  end

  assign bus.ld_ready  = (state_q == ST_IDLE);
  assign bus.ld_done   = (state_q == ST_DONE);
  assign bus.ld_rdata  = rdata_q;
  assign bus.ld_err    = err_q;
  assign bus.mem_rd_en = (state_q == ST_REQ);
  assign bus.mem_addr  = (state_q == ST_REQ) ? {addr_q[AW-1:2], 2'b00} : '0;

endmodule

// File: tb/tb_mem_load_unit.sv
// tb/tb_mem_load_unit.sv - directed scoreboard bench for mem_load_unit
module tb_mem_load_unit;
  import mem_load_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_load_unit_if #(.AW(32)) bus ();

  mem_load_unit #(.AW(32), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int passed = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  logic [32:0] sb[$];

  always @(posedge clk) begin
    if (bus.mem_rd_en) rd_cnt++;
    if (bus.ld_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] typ,
                          input logic [31:0] word, input int rv_delay,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat, input logic exp_issue);
    logic [32:0] e;
    bit seen;
    seen = 1'b0;
    sb.push_back({exp_err, exp_data});
    @(negedge clk);
    check({tag, "_ready"}, 32'(bus.ld_ready), 32'd1);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_type  = typ;
    @(posedge clk);
    #1 bus.ld_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check({tag, "_rd_en"}, 32'(bus.mem_rd_en), 32'(exp_issue));
        if (exp_issue) check({tag, "_mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
      end
      if (bus.ld_done) begin
        check({tag, "_latency"}, 32'(i), 32'(exp_lat));
        e = sb.pop_front();
        check({tag, "_rdata"}, bus.ld_rdata, e[31:0]);
        check({tag, "_err"}, 32'(bus.ld_err), 32'(e[32]));
        seen = 1'b1;
        bus.mem_rvalid = 1'b0;
        break;
      end
      if (rv_delay >= 0 && i == 2 + rv_delay) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = word;
      end else begin
        bus.mem_rvalid = 1'b0;
      end
    end
    if (!seen) begin
      check({tag, "_done_seen"}, 32'(bus.ld_done), 32'd1);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    int d0;
    int r0;
    bus.ld_valid   = 1'b0;
    bus.ld_addr    = 32'b0;
    bus.ld_type    = 3'b0;
    bus.mem_rdata  = 32'b0;
    bus.mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.ld_ready), 32'd1);
    check("rst_done", 32'(bus.ld_done), 32'd0);
    check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("rst_rdata", bus.ld_rdata, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    rst_n = 1'b1;

    run_load("lw_100", 32'h100, F3_LW, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0, 3, 1'b1);
    @(negedge clk);
    check("lw_hold_rdata", bus.ld_rdata, 32'hDEADBEEF);

    run_load("lb_103", 32'h103, F3_LB, 32'h80123456, 0, 32'hFFFFFF80, 1'b0, 3, 1'b1);
    run_load("lbu_103", 32'h103, F3_LBU, 32'h80123456, 1, 32'h00000080, 1'b0, 4, 1'b1);
    run_load("lh_102", 32'h102, F3_LH, 32'h80123456, 0, 32'hFFFF8012, 1'b0, 3, 1'b1);
    run_load("lhu_102", 32'h102, F3_LHU, 32'h80123456, 2, 32'h00008012, 1'b0, 5, 1'b1);
    run_load("lb_100", 32'h100, F3_LB, 32'h80123456, 0, 32'h00000056, 1'b0, 3, 1'b1);

    run_load("timeout", 32'h140, F3_LW, 32'h0, -1, 32'h0, 1'b1, 17, 1'b1);
    @(negedge clk);
    d0 = done_cnt;
    r0 = rd_cnt;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFEF00D;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    repeat (4) @(negedge clk);
    check("late_rvalid_done", 32'(done_cnt), 32'(d0));
    check("late_rvalid_rd", 32'(rd_cnt), 32'(r0));
    check("late_rvalid_rdata", bus.ld_rdata, 32'h0);

    r0 = rd_cnt;
    run_load("illegal_011", 32'h100, 3'b011, 32'h0, -1, 32'h0, 1'b1, 1, 1'b0);
    run_load("illegal_111", 32'h104, 3'b111, 32'h0, -1, 32'h0, 1'b1, 1, 1'b0);
    @(negedge clk);
    check("illegal_no_rd", 32'(rd_cnt), 32'(r0));

`ifdef MEM_LOAD_MISALIGN_TRAP_EN
    run_load("lh_101", 32'h101, F3_LH, 32'h12345678, -1, 32'h0, 1'b1, 1, 1'b0);
    run_load("lw_102", 32'h102, F3_LW, 32'h12345678, -1, 32'h0, 1'b1, 1, 1'b0);
`else
    run_load("lh_101", 32'h101, F3_LH, 32'h12345678, 0, 32'h00003456, 1'b0, 3, 1'b1);
    run_load("lw_102", 32'h102, F3_LW, 32'h12345678, 0, 32'h00001234, 1'b0, 3, 1'b1);
`endif
    run_load("lb_101", 32'h101, F3_LB, 32'h12345678, 0, 32'h00000056, 1'b0, 3, 1'b1);

    run_load("pre_rst", 32'h1F0, F3_LW, 32'h5A5A5A5A, 0, 32'h5A5A5A5A, 1'b0, 3, 1'b1);
    @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h200;
    bus.ld_type  = F3_LW;
    @(posedge clk);
    #1 bus.ld_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(bus.ld_ready), 32'd1);
    check("midrst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("midrst_done", 32'(bus.ld_done), 32'd0);
    check("midrst_rdata", bus.ld_rdata, 32'd0);
    check("midrst_err", 32'(bus.ld_err), 32'd0);
    d0 = done_cnt;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h11111111;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("postrst_no_done", 32'(done_cnt), 32'(d0));
    check("postrst_ready", 32'(bus.ld_ready), 32'd1);

    run_load("lw_after_rst", 32'h204, F3_LW, 32'h0BADF00D, 0, 32'h0BADF00D, 1'b0, 3, 1'b1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
